mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter DW, default 32, meaning data width of all data buses.
REQ-002 The block SHALL have parameter AW, default 32, meaning address width of all address buses.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; asserted when 0 at a clk rising edge.
REQ-005 if_req  input  1  fetch stage requests an instruction read.
REQ-006 if_addr  input  AW  fetch address (PC).
REQ-007 if_rdata  output  DW  fetched instruction.
REQ-008 if_stall  output  1  fetch not yet satisfied.
REQ-009 dm_req  input  1  memory stage requests a data access (memread or memwrite).
REQ-010 dm_we  input  1  1 = store, 0 = load.
REQ-011 dm_addr  input  AW  data address.
REQ-012 dm_wdata  input  DW  store data.
REQ-013 dm_rdata  output  DW  load data.
REQ-014 dm_stall  output  1  data access not yet satisfied.
REQ-015 adv  input  1  pipeline advances at this edge (global stall released); never depends combinationally on this block's outputs except if_stall/dm_stall.
REQ-016 mem_req, mem_we  output  1 each  request and write-enable to the shared single-port memory.
REQ-017 mem_addr  output  AW; mem_wdata  output  DW  address and store data presented to memory.
REQ-018 mem_rdata  input  DW; mem_ready  input  1  memory read data and completion strobe, meaningful only while mem_req=1.

Function
REQ-019 The state machine SHALL have states IDLE, IF_BUSY, DM_BUSY.
REQ-020 In IDLE, the arbiter SHALL move to DM_BUSY if dm_req=1 and dm_done=0; otherwise to IF_BUSY if if_req=1 and if_done=0; otherwise it SHALL stay in IDLE (data has fixed priority).
REQ-021 On the IDLE-to-BUSY edge, the arbiter SHALL latch the winning address, plus dm_we and dm_wdata for DM, into internal registers that drive mem_addr/mem_we/mem_wdata for the whole transaction.
REQ-022 mem_req SHALL be 1 exactly in IF_BUSY and DM_BUSY; mem_we SHALL be 1 only in DM_BUSY with latched we=1.
REQ-023 In a BUSY state, mem_ready=1 SHALL complete the transaction; the next state SHALL always be IDLE, so consecutive transactions are separated by one idle cycle.
REQ-024 With mem_ready=0, the arbiter SHALL remain in BUSY indefinitely with no timeout, and latched outputs SHALL stay stable.
REQ-025 Minimum latency: request seen in IDLE at cycle 0, mem_req at cycle 1, and completion in cycle 1 if mem_ready=1.
REQ-026 Per port there SHALL be a done flag and data buffer (if_done/if_buf, dm_done/dm_buf).
REQ-027 At a completion edge with adv=0, the port's done flag SHALL set and its buffer SHALL capture mem_rdata; with adv=1 neither SHALL change.
REQ-028 Any edge with adv=1 SHALL clear both done flags; clear takes effect regardless of simultaneous completion.
REQ-029 hit_x SHALL equal x_done OR (state = X_BUSY AND mem_ready).
REQ-030 x_stall SHALL equal x_req AND NOT hit_x.
REQ-031 x_rdata SHALL be x_buf when x_done=1, otherwise mem_rdata.
REQ-032 A port with done=1 SHALL not be re-granted, preventing duplicate accesses (notably duplicate stores) while the other port stalls the pipeline.
REQ-033 dm_rdata after a store SHALL be don't-care, but it SHALL not be X-propagating (buffer captures mem_rdata).
REQ-034 Requests deasserted while their transaction is in flight SHALL still complete normally; the result is buffered per REQ-027.

Reset
REQ-035 With reset=0 at an edge, the block SHALL set state=IDLE, clear both done flags and set buffers and latched address/data/we registers to 0.
REQ-036 From the cycle after reset, outputs SHALL be mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, if_rdata=dm_rdata=mem_rdata passthrough, and stalls equal to their req inputs.
REQ-037 Reset during BUSY SHALL abandon the transaction: mem_req=0 the next cycle, and the memory SHALL tolerate abandoned requests.

Verification
REQ-038 Fetch only, memory ready 0 wait cycles: if_req=1, if_addr=0x40, adv=1 -> cycle 1 mem_req=1, mem_addr=0x40, if_stall=0, if_rdata=mem_rdata; cycle 2 IDLE.
REQ-039 Simultaneous requests: if_req=dm_req=1, dm_we=1, dm_addr=0x80, dm_wdata=0xDEADBEEF, adv=~(if_stall|dm_stall), memory 2 wait cycles -> DM served first (mem_we=1, 0x80 held 3 cycles), then IF; exactly one store observed; both stalls low together.
REQ-040 Buffering: IF completes with adv=0 while DM pending, mem_rdata=0x12345678 -> if_done=1, if_rdata=0x12345678 while mem_rdata changes; no second fetch to same address.
REQ-041 Long wait: mem_ready held 0 for 20 cycles in DM_BUSY -> mem_addr/mem_wdata/mem_we stable, dm_stall=1 throughout.
REQ-042 Reset mid-op: reset=0 in DM_BUSY -> next cycle mem_req=0, state IDLE, done flags 0; after release, pending dm_req re-granted.
REQ-043 Completion with adv=1 simultaneously: done flags remain 0 and next-cycle new request is granted without repeat.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the fetch port (IF)
// and the data port (DM). Data has fixed priority. Each port owns a done
// flag and a result buffer so a finished access is held, and never reissued,
// while the other port keeps the pipeline stalled.
module mem_arbiter #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_stall,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_stall,
    input  logic          adv,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        DM_BUSY = 2'd2
    } state_t;

    state_t        state;
    logic          if_done;
    logic          dm_done;
    logic [DW-1:0] if_buf;
    logic [DW-1:0] dm_buf;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_wdata;
    logic          lat_we;

    logic          if_cmpl;
    logic          dm_cmpl;
    logic          hit_if;
    logic          hit_dm;

    // Completion of the in-flight access, per port
    assign if_cmpl = (state == IF_BUSY) && mem_ready;
    assign dm_cmpl = (state == DM_BUSY) && mem_ready;

    // Port is satisfied if already buffered or completing right now
    assign hit_if = if_done || if_cmpl;
    assign hit_dm = dm_done || dm_cmpl;

    assign if_stall = if_req && !hit_if;
    assign dm_stall = dm_req && !hit_dm;

    assign if_rdata = if_done ? if_buf : mem_rdata;
    assign dm_rdata = dm_done ? dm_buf : mem_rdata;

    // Memory request follows the state register; address/data come from latches
    assign mem_req   = (state != IDLE);
    assign mem_we    = (state == DM_BUSY) && lat_we;
    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;

    // Arbitration FSM; latches the winner's request on the grant edge
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_we    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (dm_req && !dm_done) begin
                        state     <= DM_BUSY;
                        lat_addr  <= dm_addr;
                        lat_we    <= dm_we;
                        lat_wdata <= dm_wdata;
                    end else if (if_req && !if_done) begin
                        state    <= IF_BUSY;
                        lat_addr <= if_addr;
                        lat_we   <= 1'b0;
                    end
                end
                IF_BUSY: begin
                    if (mem_ready) state <= IDLE;
                end
                DM_BUSY: begin
                    if (mem_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Done flags and result buffers; pipeline advance clears both flags
    always_ff @(posedge clk) begin
        if (!reset) begin
            if_done <= 1'b0;
            dm_done <= 1'b0;
            if_buf  <= '0;
            dm_buf  <= '0;
        end else if (adv) begin
            if_done <= 1'b0;
            dm_done <= 1'b0;
        end else begin
            if (if_cmpl) begin
                if_done <= 1'b1;
                if_buf  <= mem_rdata;
            end
            if (dm_cmpl) begin
                dm_done <= 1'b1;
                dm_buf  <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: memory model with programmable wait states,
// scoreboard queues for memory transactions and port deliveries, and a
// negedge monitor that pops and compares as the DUT presents results.
module tb_mem_arbiter;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } mem_txn_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_stall;
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [DW-1:0] dm_rdata;
    logic          dm_stall;
    logic          adv;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;

    logic          auto_adv;
    logic          adv_force;
    int            wait_cycles;
    int            mem_cnt;
    logic [DW-1:0] junk;

    mem_txn_t      exp_mem[$];
    logic [DW-1:0] exp_if[$];
    logic [DW-1:0] exp_dm[$];

    int n_cmp;
    int n_err;
    int n_store;
    int we_cyc;

    mem_arbiter #(.DW(DW), .AW(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_stall  (if_stall),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata),
        .dm_stall  (dm_stall),
        .adv       (adv),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    always #5 clk = ~clk;

    // Pipeline model: either free-running advance or a forced level
    assign adv = auto_adv ? ~(if_stall | dm_stall) : adv_force;

    // Memory model: ready after wait_cycles, read data = addr ^ 0x12345678
    assign mem_ready = mem_req && (mem_cnt >= wait_cycles);
    assign mem_rdata = mem_ready ? (mem_addr ^ 32'h1234_5678) : junk;

    always @(posedge clk) begin
        mem_cnt <= (mem_req && !mem_ready) ? mem_cnt + 1 : 0;
        junk    <= junk + 32'h0001_0003;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Monitor: pop and compare whenever memory completes or a port delivers
    always @(negedge clk) begin
        mem_txn_t t;
        logic [DW-1:0] d;
        if (mem_req && mem_we) we_cyc++;
        if (mem_req && mem_ready) begin
            if (mem_we) n_store++;
            if (exp_mem.size() == 0) begin
                fail_now($sformatf("mem_txn_unexpected addr=%0h we=%0b", mem_addr, mem_we));
            end else begin
                t = exp_mem.pop_front();
                check("mem_txn", {mem_we, mem_addr, mem_we ? mem_wdata : 32'h0},
                      {t.we, t.addr, t.we ? t.wdata : 32'h0});
            end
        end
        if (reset && if_req && !if_stall && adv) begin
            if (exp_if.size() == 0) fail_now("if_data_unexpected");
            else begin
                d = exp_if.pop_front();
                check("if_rdata", 128'(if_rdata), 128'(d));
            end
        end
        if (reset && dm_req && !dm_stall && adv && !dm_we) begin
            if (exp_dm.size() == 0) fail_now("dm_data_unexpected");
            else begin
                d = exp_dm.pop_front();
                check("dm_rdata", 128'(dm_rdata), 128'(d));
            end
        end
    end

    // mode 0: fetch accepted, 1: data accepted, 2: both in the same cycle
    task automatic wait_accept(input string name, input int mode);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (mode == 0 && if_req && !if_stall && adv) ok = 1'b1;
            if (mode == 1 && dm_req && !dm_stall && adv) ok = 1'b1;
            if (mode == 2 && if_req && dm_req && !if_stall && !dm_stall && adv) ok = 1'b1;
            if (ok) break;
        end
        if (!ok) fail_now({name, "_timeout"});
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0; n_err = 0; n_store = 0; we_cyc = 0;
        mem_cnt = 0; junk = 32'hBAD0_0000; wait_cycles = 0;
        reset = 1'b0; auto_adv = 1'b0; adv_force = 1'b1;
        if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;

        // Reset state: idle memory side, passthrough data, stall = req
        repeat (3) @(posedge clk);
        #1 if_req = 1'b1;
        @(negedge clk);
        check("rst_mem", {mem_req, mem_we, mem_addr, mem_wdata}, 66'h0);
        check("rst_stall", {if_stall, dm_stall}, 2'b10);
        check("rst_if_pass", 128'(if_rdata), 128'(mem_rdata));
        check("rst_dm_pass", 128'(dm_rdata), 128'(mem_rdata));
        @(posedge clk);
        #1 if_req = 1'b0; reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Fetch only, zero wait states, adv held high
        if_req = 1'b1; if_addr = 32'h40;
        exp_mem.push_back('{we: 1'b0, addr: 32'h40, wdata: 32'h0});
        exp_if.push_back(32'h1234_5638);
        @(negedge clk);
        check("f0_idle", {mem_req, if_stall}, 2'b01);
        @(negedge clk);
        check("f1_req", {mem_req, mem_addr, if_stall}, {1'b1, 32'h40, 1'b0});
        check("f1_pass", 128'(if_rdata), 128'(mem_rdata));
        @(posedge clk);
        #1 if_req = 1'b0;
        @(negedge clk);
        check("f2_idle", 128'(mem_req), 128'(0));

        // Simultaneous requests: store first, then fetch, one store only
        auto_adv = 1'b1; wait_cycles = 2; we_cyc = 0; n_store = 0;
        @(posedge clk);
        #1;
        if_req = 1'b1; if_addr = 32'h100;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h80; dm_wdata = 32'hDEAD_BEEF;
        exp_mem.push_back('{we: 1'b1, addr: 32'h80, wdata: 32'hDEAD_BEEF});
        exp_mem.push_back('{we: 1'b0, addr: 32'h100, wdata: 32'h0});
        exp_if.push_back(32'h1234_5778);
        wait_accept("both", 2);
        if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
        repeat (3) @(negedge clk);
        check("store_cycles", 128'(we_cyc), 128'(3));
        check("store_count", 128'(n_store), 128'(1));

        // Buffering: fetch finishes with adv=0 while a load is pending
        auto_adv = 1'b0; adv_force = 1'b0; wait_cycles = 0;
        @(posedge clk);
        #1;
        if_req = 1'b1; if_addr = 32'h0;
        exp_mem.push_back('{we: 1'b0, addr: 32'h0, wdata: 32'h0});
        exp_if.push_back(32'h1234_5678);
        @(posedge clk);
        #1;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200;
        exp_mem.push_back('{we: 1'b0, addr: 32'h200, wdata: 32'h0});
        exp_dm.push_back(32'h1234_5478);
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("if_buf_hold", {if_stall, if_rdata}, {1'b0, 32'h1234_5678});
        end
        check("dm_done_stall", 128'(dm_stall), 128'(0));
        @(posedge clk);
        #1 adv_force = 1'b1;
        @(posedge clk);
        #1 if_req = 1'b0; dm_req = 1'b0;

        // Long wait: latched store held stable, then back-to-back load
        auto_adv = 1'b1; wait_cycles = 20;
        @(posedge clk);
        #1;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h300; dm_wdata = 32'hCAFE_F00D;
        exp_mem.push_back('{we: 1'b1, addr: 32'h300, wdata: 32'hCAFE_F00D});
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("long_wait", {mem_req, mem_we, mem_addr, mem_wdata, dm_stall, mem_ready},
                  {1'b1, 1'b1, 32'h300, 32'hCAFE_F00D, 1'b1, 1'b0});
        end
        wait_accept("long_store", 1);
        // Completion coincided with adv=1: new request must win next cycle
        wait_cycles = 1; dm_we = 1'b0; dm_addr = 32'h304;
        exp_mem.push_back('{we: 1'b0, addr: 32'h304, wdata: 32'h0});
        exp_dm.push_back(32'h1234_557C);
        @(negedge clk);
        check("adv_cmpl_grant", 128'(mem_req), 128'(0));
        @(negedge clk);
        check("adv_cmpl_addr", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 32'h304});
        wait_accept("next_load", 1);
        dm_req = 1'b0;

        // Reset in DM_BUSY abandons the access; request is re-granted after
        wait_cycles = 50;
        @(posedge clk);
        #1;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h400;
        exp_mem.push_back('{we: 1'b0, addr: 32'h400, wdata: 32'h0});
        exp_dm.push_back(32'h1234_5278);
        @(negedge clk);
        @(negedge clk);
        check("rm_busy", {mem_req, mem_addr}, {1'b1, 32'h400});
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1; wait_cycles = 0;
        @(negedge clk);
        check("rm_idle", {mem_req, mem_addr, dm_stall}, {1'b0, 32'h0, 1'b1});
        wait_accept("rm_regrant", 1);
        dm_req = 1'b0;

        repeat (3) @(negedge clk);
        check("q_mem_empty", 128'(exp_mem.size()), 128'(0));
        check("q_port_empty", 128'(exp_if.size() + exp_dm.size()), 128'(0));
        check("store_total", 128'(n_store), 128'(2));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        fail_now("global_timeout");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
